vga_timing_counter: RTL and testbench
=====================================

Name: vga_timing_counter

Overview:
- Free-running horizontal/vertical timing counter for the 640x480@60 VGA path.
- Sits directly upstream of the vertical and horizontal sync FSMs and feeds them H_count, V_count, the pixel-tick enable and the line-advance enable.
- Also produces active-video flags and pixel coordinates for the image-fetch stage.
- Runs on the 100 MHz system clock and divides it down to a 25 MHz pixel-tick enable; it creates no derived clock.

Parameters:
- CLK_DIV, 4: system clocks per pixel; legal range 2..16.
- H_TOTAL, 800: pixel ticks per line; H_count range is 0..H_TOTAL-1.
- V_TOTAL, 521: lines per frame; V_count range is 0..V_TOTAL-1.
- H_ACT_START, 144: first active H_count.
- H_ACT_END, 783: last active H_count.
- V_ACT_START, 31: first active V_count.
- V_ACT_END, 510: last active V_count.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high.
- en  in  1  run enable; when low, all timing freezes.
- H_count  out  12  horizontal pixel position, registered.
- V_count  out  12  vertical line position, registered.
- H_counter_enable  out  1  one-cycle pixel-tick pulse.
- V_counter_enable  out  1  one-cycle line-advance pulse.
- frame_start  out  1  one-cycle pulse on the frame wrap.
- active  out  1  current pixel is inside the visible window.
- pix_x  out  10  active-area column, 0..639.
- pix_y  out  9  active-area row, 0..479.

Behaviour:
- Reset: async clear of the internal divider div_cnt and of H_count and V_count. All outputs read 0 while reset is held and in the first cycle after release.
  - Reset asserted mid-line or mid-frame aborts the frame immediately; counting restarts from (0,0) with no partial pulses.
- Divider: when en=1, div_cnt counts 0..CLK_DIV-1 and wraps. When en=0 it holds.
- H_counter_enable is combinational: en && div_cnt==CLK_DIV-1.
  - First pulse occurs CLK_DIV cycles after reset release (cycle index CLK_DIV-1).
- H_count increments at the clock edge that ends an H_counter_enable cycle. It wraps H_TOTAL-1 -> 0.
- V_counter_enable is combinational: H_counter_enable && H_count==H_TOTAL-1.
  - It is high in the same cycle that V_count still holds its old value. Downstream FSMs sample (V_count==N && V_counter_enable) to leave a state at the end of line N.
- V_count increments on a V_counter_enable edge and wraps V_TOTAL-1 -> 0.
- frame_start is combinational: V_counter_enable && V_count==V_TOTAL-1. It coincides with the wrap of both counters to (0,0).
- active = H_count in [H_ACT_START,H_ACT_END] && V_count in [V_ACT_START,V_ACT_END]. Both bounds are inclusive.
- pix_x = H_count-H_ACT_START and pix_y = V_count-V_ACT_START when active=1. Both are forced to 0 when active=0.
  - Subtraction is done at 12 bits, then truncated; the result is in range by construction.
- en low mid-line: counters, divider and flags hold; all pulses are 0. Resuming continues from the frozen position with no skipped or duplicated tick.
- Simultaneous wrap events (pixel, line and frame wrap on one edge) are resolved in a single cycle. There is no extra idle tick.
- Line period = H_TOTAL*CLK_DIV = 3200 clk. Frame period = 521*3200 = 1,667,200 clk.
- Implementation constraint: the design contains no latches; every combinational output has a default assignment.

Decomposition:
- Shared package vga_timing_pkg holds:
  - timing constants: H_TOTAL, V_TOTAL, active bounds, sync widths 96 and 2, porch bounds;
  - count width COUNT_W=12.
- The downstream sync FSMs import the same package constants.
- One natural sub-module: pixel_tick_div, containing the CLK_DIV prescaler. It takes clk, reset and en and outputs tick.

Test Plan:
- Reset release with en=1:
  - H_counter_enable first high at cycle 3, then every 4 cycles.
  - H_count reads 1 at cycle 4.
  - V_counter_enable first high at cycle 3199 with V_count=0; V_count=1 at cycle 3200.
- Full-frame run:
  - exactly 521 V_counter_enable pulses and one frame_start per 1,667,200 cycles;
  - frame_start coincides with H_count=799, V_count=520, then (0,0).
- Active window check:
  - (H,V)=(144,31) gives active=1, pix_x=0, pix_y=0.
  - (783,510) gives pix_x=639, pix_y=479.
  - (143,31) and (144,511) give active=0 and pix_x=pix_y=0.
- en deasserted for 37 cycles at H_count=500:
  - counts and div_cnt hold, no pulses;
  - after re-enable the next tick arrives after the remaining divider cycles, and H_count continues from 500 to 501.
- Reset asserted asynchronously mid-frame at V_count=300, H_count=412:
  - all outputs 0 within the same cycle with no clk edge needed;
  - after release, identical to the first scenario.
- Integration with the vertical sync FSM:
  - VSYNC low exactly for V_count 0..1 (2 lines = 6400 clk) per frame;
  - FSM leaves display at V_count=510 with enable high.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants, used by the timing counter and the
// downstream sync FSMs so that every block agrees on the frame geometry.
`timescale 1ns/1ps
package vga_timing_pkg;

    localparam int COUNT_W     = 12;

    localparam int CLK_DIV     = 4;
    localparam int H_TOTAL     = 800;
    localparam int V_TOTAL     = 521;
    localparam int H_ACT_START = 144;
    localparam int H_ACT_END   = 783;
    localparam int V_ACT_START = 31;
    localparam int V_ACT_END   = 510;

    // Sync pulses sit at the start of each line/frame, followed by the back porch.
    localparam int H_SYNC_W    = 96;
    localparam int V_SYNC_W    = 2;
    localparam int H_BP_START  = H_SYNC_W;
    localparam int H_FP_START  = H_ACT_END + 1;
    localparam int V_BP_START  = V_SYNC_W;
    localparam int V_FP_START  = V_ACT_END + 1;

    function automatic logic in_window(input logic [COUNT_W-1:0] val,
                                       input int lo, input int hi);
        return (val >= COUNT_W'(lo)) && (val <= COUNT_W'(hi));
    endfunction

endpackage

// File: rtl/vga_timing_counter_pixel_tick_div.sv
// Prescaler dividing the system clock down to a one-cycle pixel-tick enable;
// it holds its phase while en is low so no tick is lost or duplicated.
`timescale 1ns/1ps
module pixel_tick_div
#(
    parameter int CLK_DIV = 4
)
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);
    import vga_timing_pkg::*;

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;

    always_comb begin
        div_cnt_d = div_cnt_q;
        tick      = 1'b0;
        if (en) begin
            tick      = (div_cnt_q == DIV_LAST);
            div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/vga_timing_counter.sv
// Free-running H/V timing counter for the VGA path: pixel/line/frame pulses
// for the sync FSMs plus active-window flag and pixel coordinates for fetch.
`timescale 1ns/1ps
module vga_timing_counter
#(
    parameter int CLK_DIV     = vga_timing_pkg::CLK_DIV,
    parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
    parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
    parameter int H_ACT_START = vga_timing_pkg::H_ACT_START,
    parameter int H_ACT_END   = vga_timing_pkg::H_ACT_END,
    parameter int V_ACT_START = vga_timing_pkg::V_ACT_START,
    parameter int V_ACT_END   = vga_timing_pkg::V_ACT_END
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [11:0] H_count,
    output logic [11:0] V_count,
    output logic        H_counter_enable,
    output logic        V_counter_enable,
    output logic        frame_start,
    output logic        active,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y
);
    import vga_timing_pkg::*;

    localparam logic [COUNT_W-1:0] H_LAST = COUNT_W'(H_TOTAL - 1);
    localparam logic [COUNT_W-1:0] V_LAST = COUNT_W'(V_TOTAL - 1);

    logic [COUNT_W-1:0] h_count_q;
    logic [COUNT_W-1:0] h_count_d;
    logic [COUNT_W-1:0] v_count_q;
    logic [COUNT_W-1:0] v_count_d;
    logic               pix_tick;
    logic               line_end;
    logic               frame_end;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_div (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .tick  (pix_tick)
    );

    // Pixel, line and frame wraps all resolve on the same edge.
    always_comb begin
        line_end  = pix_tick && (h_count_q == H_LAST);
        frame_end = line_end && (v_count_q == V_LAST);
        h_count_d = h_count_q;
        v_count_d = v_count_q;
        if (pix_tick) begin
            h_count_d = line_end ? '0 : h_count_q + COUNT_W'(1);
        end
        if (line_end) begin
            v_count_d = frame_end ? '0 : v_count_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_count_q <= '0;
            v_count_q <= '0;
        end else begin
            h_count_q <= h_count_d;
            v_count_q <= v_count_d;
        end
    end

    always_comb begin
        H_count          = h_count_q;
        V_count          = v_count_q;
        H_counter_enable = pix_tick;
        V_counter_enable = line_end;
        frame_start      = frame_end;
        active           = in_window(h_count_q, H_ACT_START, H_ACT_END) &&
                           in_window(v_count_q, V_ACT_START, V_ACT_END);
        pix_x            = '0;
        pix_y            = '0;
        if (active) begin
            pix_x = 10'(h_count_q - COUNT_W'(H_ACT_START));
            pix_y = 9'(v_count_q - COUNT_W'(V_ACT_START));
        end
    end

endmodule

// File: tb/tb_vga_timing_counter.sv
// Scoreboard bench: a reduced-geometry instance and a full 640x480 instance
// share clk/reset/en and are checked against an arithmetic timing model.
`timescale 1ns/1ps
module tb_vga_timing_counter;

    localparam int S_CD = 3, S_HT = 20, S_VT = 9;
    localparam int S_HAS = 5, S_HAE = 14, S_VAS = 2, S_VAE = 6;
    localparam int D_CD = 4, D_HT = 800, D_VT = 521;
    localparam int D_HAS = 144, D_HAE = 783, D_VAS = 31, D_VAE = 510;

    typedef struct packed {
        logic        hen;
        logic        ven;
        logic        fs;
        logic        act;
        logic [11:0] h;
        logic [11:0] v;
        logic [9:0]  px;
        logic [8:0]  py;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0;

    logic [11:0] s_h, s_v, d_h, d_v;
    logic        s_hen, s_ven, s_fs, s_act, d_hen, d_ven, d_fs, d_act;
    logic [9:0]  s_px, d_px;
    logic [8:0]  s_py, d_py;

    obs_t   q_s[$];
    obs_t   q_d[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    longint n = 0;
    bit     cur_en = 1'b0;

    vga_timing_counter #(
        .CLK_DIV(S_CD), .H_TOTAL(S_HT), .V_TOTAL(S_VT),
        .H_ACT_START(S_HAS), .H_ACT_END(S_HAE),
        .V_ACT_START(S_VAS), .V_ACT_END(S_VAE)
    ) dut_s (
        .clk(clk), .reset(reset), .en(en),
        .H_count(s_h), .V_count(s_v),
        .H_counter_enable(s_hen), .V_counter_enable(s_ven),
        .frame_start(s_fs), .active(s_act), .pix_x(s_px), .pix_y(s_py)
    );

    vga_timing_counter dut_d (
        .clk(clk), .reset(reset), .en(en),
        .H_count(d_h), .V_count(d_v),
        .H_counter_enable(d_hen), .V_counter_enable(d_ven),
        .frame_start(d_fs), .active(d_act), .pix_x(d_px), .pix_y(d_py)
    );

    always #5 clk = ~clk;

    // n = enabled clock edges since reset release; everything follows from it.
    function automatic obs_t model(input longint cnt, input bit e,
                                   input int cd, input int ht, input int vt,
                                   input int has, input int hae,
                                   input int vas, input int vae);
        obs_t   r;
        longint p  = cnt / cd;
        int     dv = int'(cnt % cd);
        int     h  = int'(p % ht);
        int     v  = int'((p / ht) % vt);
        r.h   = 12'(h);
        r.v   = 12'(v);
        r.hen = e && (dv == cd - 1);
        r.ven = r.hen && (h == ht - 1);
        r.fs  = r.ven && (v == vt - 1);
        r.act = (h >= has) && (h <= hae) && (v >= vas) && (v <= vae);
        r.px  = r.act ? 10'(h - has) : 10'd0;
        r.py  = r.act ? 9'(v - vas) : 9'd0;
        return r;
    endfunction

    function automatic obs_t obs_s();
        obs_t r;
        r = '{hen: s_hen, ven: s_ven, fs: s_fs, act: s_act,
              h: s_h, v: s_v, px: s_px, py: s_py};
        return r;
    endfunction

    function automatic obs_t obs_d();
        obs_t r;
        r = '{hen: d_hen, ven: d_ven, fs: d_fs, act: d_act,
              h: d_h, v: d_v, px: d_px, py: d_py};
        return r;
    endfunction

    task automatic check_output(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d got h=%0d v=%0d hen=%b ven=%b fs=%b act=%b px=%0d py=%0d exp h=%0d v=%0d hen=%b ven=%b fs=%b act=%b px=%0d py=%0d",
                     name, cyc, got.h, got.v, got.hen, got.ven, got.fs, got.act, got.px, got.py,
                     exp.h, exp.v, exp.hen, exp.ven, exp.fs, exp.act, exp.px, exp.py);
        end
    endtask

    task automatic apply_stimulus(input bit e, input bit r);
        @(posedge clk);
        #1;
        if (cur_en && !reset) n++;
        reset  = r;
        en     = e;
        cur_en = e;
        if (r) n = 0;
        cyc++;
        q_s.push_back(model(n, e, S_CD, S_HT, S_VT, S_HAS, S_HAE, S_VAS, S_VAE));
        q_d.push_back(model(n, e, D_CD, D_HT, D_VT, D_HAS, D_HAE, D_VAS, D_VAE));
    endtask

    function automatic bit rand_en();
        return $urandom_range(0, 3) != 0;
    endfunction

    always @(negedge clk) begin
        if (q_s.size() > 0) check_output("small", obs_s(), q_s.pop_front());
        if (q_d.size() > 0) check_output("full", obs_d(), q_d.pop_front());
    end

    initial begin
        $display("[TB] start");
        for (int i = 0; i < 3; i++) apply_stimulus(rand_en(), 1'b1);
        for (int i = 0; i < 3400; i++) apply_stimulus(1'b1, 1'b0);

        begin
            bit reached = 1'b0;
            for (int i = 0; i < 8000 && !reached; i++) begin
                apply_stimulus(1'b1, 1'b0);
                reached = ((n / D_CD) % D_HT) == 500;
            end
            checks++;
            if (!reached) begin
                errors++;
                $display("[TB] FAIL freeze_setup got no H=500 within bound required H=500");
            end
        end
        for (int i = 0; i < 2; i++) apply_stimulus(1'b1, 1'b0);
        for (int i = 0; i < 37; i++) apply_stimulus(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 1'b0);

        for (int i = 0; i < 6000; i++) apply_stimulus(rand_en(), 1'b0);

        apply_stimulus(rand_en(), 1'b1);
        #1;
        check_output("async_reset_small", obs_s(), '0);
        check_output("async_reset_full", obs_d(), '0);
        for (int i = 0; i < 2; i++) apply_stimulus(rand_en(), 1'b1);
        for (int i = 0; i < 3300; i++) apply_stimulus(1'b1, 1'b0);
        for (int i = 0; i < 4000; i++) apply_stimulus(rand_en(), 1'b0);

        @(negedge clk);
        #1;
        checks++;
        if (q_s.size() != 0 || q_d.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain got %0d/%0d pending required 0/0", q_s.size(), q_d.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
